sdb_to_bin_conv: RTL and testbench

// - Converts one signed-digit binary (SDB) operand, as produced by the sdb adder datapath, back to
//   two's complement. Sits at the adder output boundary feeding conventional logic.
// - Multi-cycle chunked subtractor: value = POS - NEG, CHUNK bits per clock, ripple borrow register.
// - valid/ready handshake on input and output; one conversion in flight.

---
 rtl/sdb_to_bin_conv.sv | 133 +++++++++++++
 tb/tb_sdb_to_bin_conv.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sdb_to_bin_conv.sv
// sdb_to_bin_conv
//   Converts one signed-digit binary operand (pos/neg digit planes) to two's complement.
//   The subtraction pos - neg is done CHUNK digits per clock with a rippled borrow register,
//   so a conversion takes N = WIDTH/CHUNK clocks. One operand in flight at a time.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand present on pos/neg
//   in_ready   out  converter idle and able to accept an operand
//   pos        in   WIDTH digit plane, digit i = +1 when pos[i]=1, neg[i]=0
//   neg        in   WIDTH digit plane, digit i = -1 when pos[i]=0, neg[i]=1 (11 is illegal)
//   out_valid  out  result/err valid, held until out_ready
//   out_ready  in   downstream accepts the result
//   result     out  WIDTH+1 two's complement value of the operand
//   err        out  accepted operand held at least one illegal (11) digit
//   zero       out  result is zero (only when SDB_CONV_ZERO_FLAG_EN is defined)
//
// Configuration
//   SDB_CONV_ZERO_FLAG_EN  adds the 'zero' output, registered with the final chunk.

module sdb_to_bin_conv #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] pos,
   input  logic [WIDTH-1:0] neg,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   result,
   output logic             err
`ifdef SDB_CONV_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   localparam int unsigned N    = WIDTH / CHUNK;
   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

   typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] pos_q;
   logic [WIDTH-1:0] neg_q;
   logic             borrow_q;
   logic [CntW-1:0]  cnt_q;

   logic [31:0]      shamt;
   logic [WIDTH-1:0] pos_sh;
   logic [WIDTH-1:0] neg_sh;
   logic [CHUNK:0]   diff;
   logic [WIDTH-1:0] chunk_mask;
   logic [WIDTH-1:0] result_upd;
   logic [WIDTH-1:0] illegal;

   // Current chunk: {0,pos_c} - {0,neg_c} - borrow; the top bit is the outgoing borrow.
   always_comb begin
      shamt      = CHUNK * cnt_q;
      pos_sh     = pos_q >> shamt;
      neg_sh     = neg_q >> shamt;
      diff       = {1'b0, pos_sh[CHUNK-1:0]} - {1'b0, neg_sh[CHUNK-1:0]}
                   - {{CHUNK{1'b0}}, borrow_q};
      chunk_mask = WIDTH'({CHUNK{1'b1}}) << shamt;
      result_upd = (result[WIDTH-1:0] & ~chunk_mask)
                   | ((WIDTH'(diff[CHUNK-1:0]) << shamt) & chunk_mask);
      illegal    = pos & neg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         err       <= 1'b0;
         borrow_q  <= 1'b0;
         cnt_q     <= '0;
         pos_q     <= '0;
         neg_q     <= '0;
`ifdef SDB_CONV_ZERO_FLAG_EN
         zero      <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  // Illegal digits convert as 0 but are flagged.
                  pos_q    <= pos & ~illegal;
                  neg_q    <= neg & ~illegal;
                  err      <= |illegal;
                  borrow_q <= 1'b0;
                  cnt_q    <= '0;
                  in_ready <= 1'b0;
                  state_q  <= StConv;
               end
            end
            StConv: begin
               result[WIDTH-1:0] <= result_upd;
               borrow_q          <= diff[CHUNK];
               cnt_q             <= cnt_q + CntW'(1);
               if (cnt_q == LastCnt) begin
                  // Final borrow is the sign of the full-width difference.
                  result[WIDTH] <= diff[CHUNK];
                  out_valid     <= 1'b1;
                  state_q       <= StDone;
`ifdef SDB_CONV_ZERO_FLAG_EN
                  zero          <= ~(|result_upd | diff[CHUNK]);
`endif
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_q   <= StIdle;
               end
            end
            default: begin
               state_q   <= StIdle;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdb_to_bin_conv.sv
// tb_sdb_to_bin_conv
//   Directed bench for sdb_to_bin_conv with WIDTH=8, CHUNK=2 (4 conversion cycles).
//   Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_sdb_to_bin_conv;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] pos;
   logic [7:0] neg;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] result;
   logic       err;
`ifdef SDB_CONV_ZERO_FLAG_EN
   logic       zero;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   sdb_to_bin_conv #(
      .WIDTH (8),
      .CHUNK (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pos       (pos),
      .neg       (neg),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .err       (err)
`ifdef SDB_CONV_ZERO_FLAG_EN
      ,
      .zero      (zero)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for out_valid, returning the number of edges taken (bounded).
   task automatic wait_valid(output int edges);
      edges = 0;
      while (!out_valid && edges < 20) begin
         tick();
         edges++;
      end
   endtask

   // Full transaction with immediate out_ready after completion.
   task automatic run_op(input string tag, input logic [7:0] p, input logic [7:0] n,
                         input logic [8:0] exp_res, input logic exp_err);
      int edges;
      pos      = p;
      neg      = n;
      in_valid = 1'b1;
      tick();                               // accepting edge
      in_valid = 1'b0;
      pos      = ~p;                        // must not disturb the in-flight operand
      neg      = 8'h00;
      check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
      wait_valid(edges);
      check({tag, " latency"}, 32'(edges), 32'd4);
      check({tag, " result"}, 32'(result), 32'(exp_res));
      check({tag, " err"}, 32'(err), 32'(exp_err));
`ifdef SDB_CONV_ZERO_FLAG_EN
      check({tag, " zero"}, 32'(zero), 32'(exp_res == 9'h000));
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int edges;
      int seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      pos       = 8'h00;
      neg       = 8'h00;
      tick();
      tick();
      rst = 1'b0;

      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset result", 32'(result), 32'd0);
      check("reset err", 32'(err), 32'd0);
`ifdef SDB_CONV_ZERO_FLAG_EN
      check("reset zero", 32'(zero), 32'd0);
`endif

      run_op("p0F_n00", 8'h0F, 8'h00, 9'h00F, 1'b0);
      run_op("p00_n01", 8'h00, 8'h01, 9'h1FF, 1'b0);
      run_op("p80_n7F", 8'h80, 8'h7F, 9'h001, 1'b0);
      run_op("p00_nFF", 8'h00, 8'hFF, 9'h101, 1'b0);
      run_op("pFF_n00", 8'hFF, 8'h00, 9'h0FF, 1'b0);
      run_op("p03_n01", 8'h03, 8'h01, 9'h002, 1'b1);
      run_op("p5A_nA5", 8'h5A, 8'hA5, 9'h1B5, 1'b0);   // 90 - 165 = -75
`ifdef SDB_CONV_ZERO_FLAG_EN
      run_op("p02_n02", 8'h02, 8'h02, 9'h000, 1'b1);
      run_op("p02_n01", 8'h02, 8'h01, 9'h001, 1'b0);
`endif

      // Backpressure: hold DONE with a second operand waiting.
      pos      = 8'h0F;
      neg      = 8'h00;
      in_valid = 1'b1;
      tick();
      pos = 8'h05;                          // second operand, held by producer
      neg = 8'h00;
      wait_valid(edges);
      check("bp first latency", 32'(edges), 32'd4);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp out_valid held", 32'(out_valid), 32'd1);
         check("bp result held", 32'(result), 32'h00F);
         check("bp in_ready low", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp release out_valid", 32'(out_valid), 32'd0);
      check("bp release in_ready", 32'(in_ready), 32'd1);
      tick();                               // second operand accepted here
      in_valid = 1'b0;
      check("bp second accepted", 32'(in_ready), 32'd0);
      wait_valid(edges);
      check("bp second latency", 32'(edges), 32'd4);
      check("bp second result", 32'(result), 32'h005);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset on the second CONV edge discards the operand.
      pos      = 8'hFF;
      neg      = 8'h03;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();                               // first CONV edge
      rst = 1'b1;
      tick();                               // second CONV edge, reset wins
      rst = 1'b0;
      check("midrst in_ready", 32'(in_ready), 32'd1);
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst result", 32'(result), 32'd0);
      check("midrst err", 32'(err), 32'd0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid) seen++;
      end
      check("midrst no stale out_valid", 32'(seen), 32'd0);

      // Converter still works after the aborted operation.
      run_op("post_rst", 8'h10, 8'h01, 9'h00F, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
